// File: rtl/p2s_rr_arbiter.sv
// Purpose  : round-robin share of one p2s serializer among M parallel-word requesters.
// Latency  : accept c0, p2s handshake c1, bits c2..c(N+1), done c(N+2), next accept c(N+3).
// Backpress: p2s_par_ready low holds the word in OFFER; a serial-side stall just lengthens SERIAL.
//
// Ports
//   clk, rstn      rising-edge clock, asynchronous active-low reset
//   req_valid[M]   requester i has a word on req_data[i*N +: N]
//   req_ready[M]   one-hot accept, only asserted in IDLE (combinational from state, ptr, req_valid)
//   p2s_par_*      parallel-side handshake toward the serializer; data comes from the hold register
//   chan_id        channel being offered/serialized, 0 when idle
//   busy           high whenever a word is owned (OFFER or SERIAL)
//   done[M]        one-cycle one-hot pulse when the owned word has left the serializer

module p2s_rr_arbiter #(
    parameter int N  = 4,
    parameter int M  = 3,
    localparam int CW = $clog2(M)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [M-1:0]    req_valid,
    input  logic [M*N-1:0]  req_data,
    output logic [M-1:0]    req_ready,
    input  logic            p2s_par_ready,
    output logic            p2s_par_valid,
    output logic [N-1:0]    p2s_par_data,
    output logic [CW-1:0]   chan_id,
    output logic            busy,
    output logic [M-1:0]    done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_SERIAL = 2'd2
    } state_t;

    // M expressed in the width used for the wrap-around sum below.
    localparam logic [CW:0] M_W = (CW+1)'(M);

    state_t          state, state_nxt;
    logic [CW-1:0]   ptr;     // highest-priority channel for the next grant
    logic [CW-1:0]   gnt;     // channel that owns the current word
    logic [N-1:0]    hold;    // captured word, stable for the whole OFFER/SERIAL span

    logic            any_vld;
    logic [CW-1:0]   pick;
    logic            accept;
    logic            finish;

    function automatic logic [M-1:0] onehot(input logic [CW-1:0] idx);
        logic [M-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin scan starting at ptr. The sum is one bit wider than ptr so
    // that wrapping modulo a non-power-of-two M is a single subtract.
    always_comb begin
        logic [CW:0]   sum;
        logic [CW-1:0] idx;
        any_vld = 1'b0;
        pick    = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < M; k++) begin
            sum = {1'b0, ptr} + (CW+1)'(k);
            if (sum >= M_W) begin
                sum = sum - M_W;
            end
            idx = sum[CW-1:0];
            if (!any_vld && req_valid[idx]) begin
                any_vld = 1'b1;
                pick    = idx;
            end
        end
    end

    // The grant is taken the same cycle it is offered; it never waits on p2s.
    assign accept = (state == ST_IDLE) && any_vld;

    // p2s raises par_ready again only once it has shifted the whole word out
    // and returned to its receive state; the cycle after the handshake it is
    // guaranteed low, so seeing it high in SERIAL marks completion.
    assign finish = (state == ST_SERIAL) && p2s_par_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_vld) begin
                    state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (p2s_par_ready) begin
                    state_nxt = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (p2s_par_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold <= '0;
            gnt  <= '0;
        end else if (accept) begin
            hold <= req_data[pick*N +: N];
            gnt  <= pick;
        end
    end

    // Priority moves to the channel after the one just served, so a channel
    // that keeps requesting waits at most M-1 words.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (finish) begin
            ptr <= (gnt == CW'(M-1)) ? '0 : gnt + CW'(1);
        end
    end

    // rstn gates the combinational outputs so that nothing is accepted or
    // reported while reset is held, even with requests pending.
    always_comb begin
        req_ready = '0;
        done      = '0;
        if (rstn && accept) begin
            req_ready = onehot(pick);
        end
        if (rstn && finish) begin
            done = onehot(gnt);
        end
    end

    // par_valid is dropped in SERIAL so the serializer cannot restart on the
    // same word when it comes back to its receive state.
    assign p2s_par_valid = (state == ST_OFFER);
    assign p2s_par_data  = hold;
    assign chan_id       = (state == ST_IDLE) ? '0 : gnt;
    assign busy          = (state != ST_IDLE);

    a_req_ready_onehot : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(req_ready));
    a_done_onehot : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(done));
    a_no_ready_when_busy : assert property (@(posedge clk) disable iff (!rstn)
        busy |-> (req_ready == '0));

endmodule
